// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch path.
package cpu_pkg;

  localparam int INST_WIDTH = 32;
  localparam logic [31:0] PC_INCR = 32'd4;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_BUSY  = 2'd1,
    FETCH_WRITE = 2'd2
  } fetch_state_t;

  typedef logic [1:0] fault_cause_t;

  localparam fault_cause_t FETCH_FAULT_NONE        = 2'b00;
  localparam fault_cause_t FETCH_FAULT_MISALIGNED  = 2'b01;
  localparam fault_cause_t FETCH_FAULT_BUS_TIMEOUT = 2'b10;

  // Instructions are word aligned; any set low bit is a fault.
  function automatic logic addr_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/cpu_fetch_timeout.sv
// Counts BUSY cycles without a bus acknowledge and flags expiry.
module cpu_fetch_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst, clear, enable};
      assign expired = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

      logic [CW-1:0] count_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          count_reg <= '0;
        end else if (clear) begin
          count_reg <= '0;
        end else if (enable) begin
          count_reg <= count_reg + CW'(1);
        end
      end

      // Expiry is only meaningful on a cycle that would otherwise keep waiting.
      assign expired = enable && (count_reg == LIMIT);
    end
  endgenerate

endmodule

// File: rtl/cpu_fetch_unit.sv
// Instruction fetch: owns the PC, runs one bus read per start, loads the IR.
module cpu_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  pc_wr,
  input  logic [31:0]           pc_in,
  output logic [31:0]           pc,
  output logic [31:0]           inst_pc,
  output logic [31:0]           mem_addr,
  output logic                  mem_rd,
  input  logic                  mem_ack,
  input  logic [INST_WIDTH-1:0] mem_data,
  output logic [INST_WIDTH-1:0] ir_data,
  output logic                  ir_wr,
  output logic                  done,
  output logic                  fault,
  output logic [1:0]            fault_cause
);

  fetch_state_t state_reg, state_next;

  logic [31:0] ea;
  logic        ea_misaligned;
  logic        in_idle;
  logic        in_busy;
  logic        accept;
  logic        tmo_enable;
  logic        tmo_expired;

  assign in_idle       = (state_reg == FETCH_IDLE);
  assign in_busy       = (state_reg == FETCH_BUSY);
  assign ea            = pc_wr ? pc_in : pc;
  assign ea_misaligned = addr_misaligned(ea[1:0]);
  assign accept        = in_idle && start && !ea_misaligned;
  assign tmo_enable    = in_busy && !mem_ack;

  cpu_fetch_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .enable (tmo_enable),
    .expired(tmo_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= FETCH_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      FETCH_IDLE: begin
        if (accept) state_next = FETCH_BUSY;
      end
      FETCH_BUSY: begin
        if (mem_ack)          state_next = FETCH_WRITE;
        else if (tmo_expired) state_next = FETCH_IDLE;
      end
      FETCH_WRITE: state_next = FETCH_IDLE;
      default:     state_next = FETCH_IDLE;
    endcase
  end

  // Bus request and IR strobe come straight from state, so reset drops them at once.
  always_comb begin
    mem_rd = 1'b0;
    ir_wr  = 1'b0;
    done   = 1'b0;
    unique case (state_reg)
      FETCH_BUSY:  mem_rd = 1'b1;
      FETCH_WRITE: begin
        ir_wr = 1'b1;
        done  = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      inst_pc     <= RESET_PC;
      ir_data     <= '0;
      fault_cause <= FETCH_FAULT_NONE;
      fault       <= 1'b0;
    end else begin
      fault <= 1'b0;
      if (in_idle) begin
        if (start) begin
          pc <= ea;
          if (ea_misaligned) begin
            fault_cause <= FETCH_FAULT_MISALIGNED;
            fault       <= 1'b1;
          end else begin
            fault_cause <= FETCH_FAULT_NONE;
          end
        end else if (pc_wr) begin
          pc <= pc_in;
        end
      end else if (in_busy) begin
        // An ack on the expiry cycle still completes the fetch.
        if (mem_ack) begin
          ir_data <= mem_data;
          inst_pc <= pc;
          pc      <= pc + PC_INCR;
        end else if (tmo_expired) begin
          fault_cause <= FETCH_FAULT_BUS_TIMEOUT;
          fault       <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Scoreboard bench for cpu_fetch_unit: directed corner cases plus random fetches.
module tb_cpu_fetch_unit;

  localparam int          TMO      = 4;
  localparam logic [31:0] RST_PC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        pc_wr = 1'b0;
  logic [31:0] pc_in = '0;
  logic [31:0] pc;
  logic [31:0] inst_pc;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_data = '0;
  logic [31:0] ir_data;
  logic        ir_wr;
  logic        done;
  logic        fault;
  logic [1:0]  fault_cause;

  cpu_fetch_unit #(
    .RESET_PC      (RST_PC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pc_wr      (pc_wr),
    .pc_in      (pc_in),
    .pc         (pc),
    .inst_pc    (inst_pc),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data),
    .ir_data    (ir_data),
    .ir_wr      (ir_wr),
    .done       (done),
    .fault      (fault),
    .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_fault;
    logic [1:0]  cause;
    logic [31:0] ir;
    logic [31:0] ipc;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  logic [31:0] model_pc  = RST_PC;
  logic [31:0] model_ipc = RST_PC;
  logic [31:0] model_ir  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ir_wr/done/fault pulse must match the oldest expected outcome.
  always @(negedge clk) begin
    if (!rst && (ir_wr || done || fault)) begin
      check("ir_wr_eq_done", 32'(ir_wr), 32'(done));
      check("done_and_fault", 32'(done & fault), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_output", {29'd0, ir_wr, done, fault}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        txn++;
        $display("txn %0d: %s pc=%h inst_pc=%h ir=%h cause=%0d",
                 txn, e.is_fault ? "fault" : "done", pc, inst_pc, ir_data, fault_cause);
        check("outcome_is_fault", 32'(fault), 32'(e.is_fault));
        check("fault_cause", 32'(fault_cause), 32'(e.cause));
        check("pc", pc, e.pc);
        check("inst_pc", inst_pc, e.ipc);
        check("ir_data", ir_data, e.ir);
      end
    end
  end

  // n is the BUSY cycle (1-based) on which ack arrives; n > TMO means no ack.
  task automatic do_fetch(input bit pcwr, input logic [31:0] pcin, input int n,
                          input logic [31:0] data, input bit junk);
    logic [31:0] ea;
    exp_t e;
    int last;
    ea = pcwr ? pcin : model_pc;
    if (ea[1:0] != 2'b00) begin
      model_pc = ea;
      e = '{1'b1, 2'b01, model_ir, model_ipc, model_pc};
    end else if (n <= TMO) begin
      model_ir  = data;
      model_ipc = ea;
      model_pc  = ea + 32'd4;
      e = '{1'b0, 2'b00, model_ir, model_ipc, model_pc};
    end else begin
      model_pc = ea;
      e = '{1'b1, 2'b10, model_ir, model_ipc, model_pc};
    end
    exp_q.push_back(e);

    @(negedge clk);
    start = 1'b1; pc_wr = pcwr; pc_in = pcin; mem_ack = 1'b0;
    @(negedge clk);
    start = 1'b0; pc_wr = 1'b0; pc_in = $urandom;
    if (ea[1:0] != 2'b00) begin
      check("misaligned_fault_pulse", 32'(fault), 32'd1);
      check("misaligned_no_rd", 32'(mem_rd), 32'd0);
      return;
    end
    last = (n < TMO) ? n : TMO;
    for (int i = 1; i <= last; i++) begin
      if (i > 1) @(negedge clk);
      check("busy_mem_rd", 32'(mem_rd), 32'd1);
      check("busy_mem_addr", mem_addr, ea);
      mem_ack  = (i == n);
      mem_data = (i == n) ? data : $urandom;
      if (junk) begin
        start = 1'($urandom); pc_wr = 1'($urandom); pc_in = $urandom;
      end
    end
    @(negedge clk);
    mem_ack = 1'b0; start = 1'b0; pc_wr = 1'b0;
    if (n <= TMO) check("done_latency", 32'(ir_wr), 32'd1);
    else          check("timeout_latency", 32'(fault), 32'd1);
    check("rd_dropped", 32'(mem_rd), 32'd0);
  endtask

  task automatic reset_mid_busy();
    @(negedge clk);
    start = 1'b1; pc_wr = 1'b1; pc_in = 32'h0000_0040;
    @(negedge clk);
    start = 1'b0; pc_wr = 1'b0;
    check("pre_reset_rd", 32'(mem_rd), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("reset_rd_drop", 32'(mem_rd), 32'd0);
    check("reset_pc", pc, RST_PC);
    check("reset_inst_pc", inst_pc, RST_PC);
    @(negedge clk);
    rst = 1'b0;
    model_pc = RST_PC; model_ipc = RST_PC; model_ir = '0;
    mem_ack = 1'b1; mem_data = $urandom;
    @(negedge clk);
    @(negedge clk);
    mem_ack = 1'b0;
    check("late_ack_no_ir_wr", 32'(ir_wr), 32'd0);
    check("late_ack_no_rd", 32'(mem_rd), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_pc", pc, RST_PC);
    check("rst_inst_pc", inst_pc, RST_PC);
    check("rst_ir_data", ir_data, 32'd0);
    check("rst_fault_cause", 32'(fault_cause), 32'd0);
    check("rst_strobes", {28'd0, mem_rd, ir_wr, done, fault}, 32'd0);
    rst = 1'b0;

    do_fetch(1'b0, 32'h0, 1, 32'h0050_0093, 1'b0);
    do_fetch(1'b1, 32'h0000_0100, 4, 32'h1234_5678, 1'b0);
    do_fetch(1'b1, 32'h0000_0102, 1, 32'hDEAD_BEEF, 1'b0);
    do_fetch(1'b1, 32'h0000_0200, 1, 32'h0000_0013, 1'b0);
    do_fetch(1'b0, 32'h0, TMO + 1, 32'h0, 1'b0);
    do_fetch(1'b1, 32'hFFFF_FFFC, 2, 32'hCAFE_F00D, 1'b1);
    reset_mid_busy();

    for (int t = 0; t < 150; t++) begin
      logic [31:0] addr;
      int sel;
      sel = $urandom_range(0, 15);
      if (sel < 2)       addr = $urandom | 32'h1;
      else if (sel == 2) addr = 32'hFFFF_FFF8 + {$urandom_range(0, 1), 2'b00};
      else               addr = {$urandom, 2'b00} >> 0 & 32'hFFFF_FFFC;
      do_fetch(1'($urandom), addr, $urandom_range(1, TMO + 2), $urandom, 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        mem_ack = 1'b1; mem_data = $urandom;
        @(negedge clk);
        mem_ack = 1'b0;
      end
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_fetch_unit.md
Name: cpu_fetch_unit

Overview:
- Producer side of the instruction register's load interface.
- Owns the program counter and runs one instruction fetch per control-unit request, using a req/ack handshake on the memory bus.
- Delivers the fetched word as ir_data plus a one-cycle ir_wr strobe.
- Reports misaligned-PC and bus-timeout faults to the control unit for trap entry.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- TIMEOUT_CYCLES, 255: BUSY cycles without mem_ack before a timeout fault; 0 disables the timeout.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  fetch request from the control unit; sampled in IDLE only.
- pc_wr  in  1  load pc from pc_in (jump, branch, trap, sret); honoured in IDLE only.
- pc_in  in  32  new PC value.
- pc  out  32  address of the next fetch.
- inst_pc  out  32  PC of the instruction currently held in the IR (for auipc, jal, epc).
- mem_addr  out  32  fetch address; equals pc.
- mem_rd  out  1  read request; high throughout BUSY.
- mem_ack  in  1  read completion; mem_data valid in the same cycle.
- mem_data  in  32  read data.
- ir_data  out  32  registered instruction word.
- ir_wr  out  1  one-cycle IR load strobe.
- done  out  1  one-cycle successful-fetch pulse.
- fault  out  1  one-cycle fault pulse.
- fault_cause  out  2  00 none, 01 misaligned, 10 bus timeout; held until the next accepted start.

Behaviour:
- Reset (async): state=IDLE, pc=inst_pc=RESET_PC, ir_data=0, fault_cause=00, counter=0. mem_rd, ir_wr, done and fault all 0. A reset during BUSY drops mem_rd immediately; any late mem_ack is ignored.
- States: IDLE, BUSY, WRITE.
- IDLE:
  - Effective address ea = pc_wr ? pc_in : pc. pc_wr alone loads pc<=pc_in.
  - start with ea[1:0]!=0: pc<=ea, fault_cause<=01, fault=1 in the next cycle, stay IDLE, no bus request.
  - start with aligned ea: pc<=ea, fault_cause<=00, counter<=0, go to BUSY.
- BUSY:
  - mem_rd=1; mem_addr=pc, stable for the whole state. start and pc_wr are ignored.
  - On mem_ack: ir_data<=mem_data, inst_pc<=pc, pc<=pc+4 (32-bit wrap: 32'hFFFF_FFFC -> 0), go to WRITE.
  - Otherwise counter increments. When counter==TIMEOUT_CYCLES-1 with no ack (TIMEOUT_CYCLES!=0): fault_cause<=10, fault pulse, return to IDLE with pc unchanged.
  - mem_ack in the same cycle as timeout expiry: ack wins, no fault.
- WRITE: lasts one cycle; ir_wr=1 and done=1, go to IDLE. The IR latches at the end of this cycle.
- Latency: start accepted at cycle 0; mem_rd from cycle 1; ack at cycle k gives ir_wr/done at cycle k+1. A zero-wait memory (ack at cycle 1) gives done at cycle 2.
- The earliest next start is sampled in the cycle after WRITE.
- mem_ack outside BUSY is ignored.
- done and fault are never asserted together. ir_wr is asserted only in WRITE.

Decomposition:
- Shared package cpu_pkg:
  - fetch state enum (IDLE/BUSY/WRITE).
  - FETCH_FAULT_NONE/MISALIGNED/BUS_TIMEOUT constants.
  - INST_WIDTH=32 and the PC increment constant 4.
- Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1.
- One sub-module: cpu_fetch_timeout (clear, enable, expired; parameterised by TIMEOUT_CYCLES). Everything else stays in cpu_fetch_unit.

Test Plan:
- Reset then start with 1-cycle ack and mem_data=32'h00500093 -> mem_addr=0; ir_wr/done at cycle 2; ir_data=32'h00500093, inst_pc=0, pc=4.
- pc_wr=1 with pc_in=32'h0000_0100 alongside start, ack after 3 wait cycles -> mem_addr=0x100 held stable with mem_rd high for 4 cycles; then pc=0x104, inst_pc=0x100.
- pc_wr with pc_in=32'h0000_0102 then start -> fault pulse, fault_cause=01, mem_rd never asserted, pc=0x102; a following aligned pc_wr plus start clears fault_cause to 00.
- TIMEOUT_CYCLES=4, no ack -> fault after 4 BUSY cycles, fault_cause=10, pc unchanged. Repeat with ack on the 4th cycle -> done, no fault.
- pc=32'hFFFF_FFFC fetch completes -> pc=0, inst_pc=32'hFFFF_FFFC. start/pc_wr pulsed during BUSY -> no effect.
- Assert rst mid-BUSY -> mem_rd low the same cycle, pc=RESET_PC, state IDLE. An ack after reset release produces no ir_wr.
